regfile_pair: RTL and testbench

- Parametrised successor to the 16×4 index register file.
- Adds a synchronous clear, 4004-style register-pair access on both read and write, and a registered read port with write-first bypass.
- Adds a two-cycle increment engine that sets a zero flag, used for INC/ISZ execution.
- Sits between the instruction decoder/ALU and the accumulator path.

---
 rtl/regfile_pair.sv | 123 ++++++++++++
 tb/tb_regfile_pair.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/regfile_pair.sv
// Register file with single/pair read and write, a registered write-first read port,
// and a two-cycle increment engine (capture, writeback) that reports a zero flag.
module regfile_pair #(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    rd_en_i,
  input  logic                    rd_pair_i,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
  output logic [2*DATA_WIDTH-1:0] rd_data_o,
  output logic                    rd_valid_o,
  input  logic                    wr_en_i,
  input  logic                    wr_pair_i,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [2*DATA_WIDTH-1:0] wr_data_i,
  input  logic                    inc_en_i,
  input  logic [ADDR_WIDTH-1:0]   inc_addr_i,
  output logic                    inc_busy_o,
  output logic                    inc_done_o,
  output logic                    inc_zero_o
);

  typedef enum logic [1:0] {IDLE, CAP, WB} inc_state_e;

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  inc_state_e                          state_q, state_d;
  logic [ADDR_WIDTH-1:0]               inc_addr_q, inc_addr_d;
  logic [DATA_WIDTH-1:0]               inc_res_q, inc_res_d;
  logic                                inc_done_q, inc_done_d;
  logic                                inc_zero_q, inc_zero_d;
  logic [2*DATA_WIDTH-1:0]             rd_data_q, rd_data_d;
  logic                                rd_valid_q;
  logic [ADDR_WIDTH-1:0]               rd_even, rd_odd;

  // Post-edge register values; the external write is applied last so it wins
  // over an increment writeback to the same register.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (state_q == WB && inc_addr_q == ADDR_WIDTH'(i))
        regs_d[i] = inc_res_q;
      if (wr_en_i) begin
        if (wr_pair_i) begin
          if ((wr_addr_i >> 1) == ADDR_WIDTH'(i / 2))
            regs_d[i] = ((i % 2) == 0) ? wr_data_i[2*DATA_WIDTH-1:DATA_WIDTH]
                                       : wr_data_i[DATA_WIDTH-1:0];
        end else if (wr_addr_i == ADDR_WIDTH'(i)) begin
          regs_d[i] = wr_data_i[DATA_WIDTH-1:0];
        end
      end
    end
  end

  // Reads see regs_d, which gives write-first bypass nibble by nibble.
  always_comb begin
    rd_even   = rd_addr_i & ~ONE;
    rd_odd    = rd_even | ONE;
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      if (rd_pair_i) rd_data_d = {regs_d[rd_even], regs_d[rd_odd]};
      else           rd_data_d = {{DATA_WIDTH{1'b0}}, regs_d[rd_addr_i]};
    end
  end

  always_comb begin
    state_d    = state_q;
    inc_addr_d = inc_addr_q;
    inc_res_d  = inc_res_q;
    inc_done_d = 1'b0;
    inc_zero_d = inc_zero_q;
    case (state_q)
      IDLE: if (inc_en_i) begin
        state_d    = CAP;
        inc_addr_d = inc_addr_i;
      end
      CAP: begin
        // Operand includes any write landing on the target at this edge.
        inc_res_d = regs_d[inc_addr_q] + DATA_WIDTH'(1);
        state_d   = WB;
      end
      WB: begin
        inc_done_d = 1'b1;
        inc_zero_d = (inc_res_q == '0);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      regs_q     <= '0;
      state_q    <= IDLE;
      inc_addr_q <= '0;
      inc_res_q  <= '0;
      inc_done_q <= 1'b0;
      inc_zero_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      state_q    <= state_d;
      inc_addr_q <= inc_addr_d;
      inc_res_q  <= inc_res_d;
      inc_done_q <= inc_done_d;
      inc_zero_q <= inc_zero_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en_i;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign inc_busy_o = (state_q != IDLE);
  assign inc_done_o = inc_done_q;
  assign inc_zero_o = inc_zero_q;

endmodule

// File: tb/tb_regfile_pair.sv
// Scoreboarded bench for regfile_pair: reads push expectations from a register model,
// the registered read port pops them; increment status is checked cycle by cycle.
module tb_regfile_pair;
  localparam int DW = 4;
  localparam int NR = 16;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          rd_en, rd_pair, wr_en, wr_pair, inc_en;
  logic [AW-1:0] rd_addr, wr_addr, inc_addr;
  logic [2*DW-1:0] rd_data, wr_data;
  logic          rd_valid, inc_busy, inc_done, inc_zero;

  regfile_pair #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .clock_i(clock), .reset_i(reset),
    .rd_en_i(rd_en), .rd_pair_i(rd_pair), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .wr_en_i(wr_en), .wr_pair_i(wr_pair), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .inc_en_i(inc_en), .inc_addr_i(inc_addr),
    .inc_busy_o(inc_busy), .inc_done_o(inc_done), .inc_zero_o(inc_zero)
  );

  always #5 clock = ~clock;

  logic [DW-1:0]   m [NR];
  logic [2*DW-1:0] exp_q [$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle_in();
    rd_en = 0; rd_pair = 0; rd_addr = '0;
    wr_en = 0; wr_pair = 0; wr_addr = '0; wr_data = '0;
    inc_en = 0; inc_addr = '0;
  endtask

  task automatic wr1(input int a, input logic [DW-1:0] d);
    wr_en = 1; wr_pair = 0; wr_addr = AW'(a); wr_data = {{DW{1'b0}}, d};
    m[a] = d;
  endtask

  task automatic wrp(input int a, input logic [2*DW-1:0] d);
    wr_en = 1; wr_pair = 1; wr_addr = AW'(a); wr_data = d;
    m[a & ~1] = d[2*DW-1:DW];
    m[a | 1]  = d[DW-1:0];
  endtask

  task automatic rd1(input int a);
    rd_en = 1; rd_pair = 0; rd_addr = AW'(a);
    exp_q.push_back({{DW{1'b0}}, m[a]});
  endtask

  task automatic rdp(input int a);
    rd_en = 1; rd_pair = 1; rd_addr = AW'(a);
    exp_q.push_back({m[a & ~1], m[a | 1]});
  endtask

  task automatic inc(input int a);
    inc_en = 1; inc_addr = AW'(a);
  endtask

  task automatic tick();
    logic exp_v;
    logic [2*DW-1:0] e;
    exp_v = rd_en & ~reset;
    @(posedge clock); #1;
    chk("rd_valid", rd_valid, exp_v);
    if (rd_valid) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_data", rd_data, e);
      end else chk("rd_extra", rd_valid, 1'b0);
    end
    idle_in();
  endtask

  task automatic inc_st(input string tag, input logic b, input logic d, input logic z);
    chk({tag, "_busy"}, inc_busy, b);
    chk({tag, "_done"}, inc_done, d);
    if (d) chk({tag, "_zero"}, inc_zero, z);
  endtask

  initial begin
    idle_in();
    reset = 1;
    tick();
    reset = 0;
    foreach (m[i]) m[i] = '0;
    chk("rst_rd_data", rd_data, 0);
    inc_st("rst", 0, 0, 0);
    chk("rst_zero", inc_zero, 0);

    // reset clears every register
    for (int i = 0; i < NR; i++) begin wr1(i, 4'hA); tick(); end
    rd1(0); tick();
    reset = 1; tick(); reset = 0;
    foreach (m[i]) m[i] = '0;
    chk("post_rst_valid", rd_valid, 0);
    for (int i = 0; i < NR; i++) begin rd1(i); tick(); end

    // pair access
    wrp(4, 8'h3C); tick();
    rd1(4); tick();
    rd1(5); tick();
    rdp(5); tick();

    // write-first bypass, full and nibble-wise
    wr1(7, 4'h2); tick();
    wr1(7, 4'h9); rd1(7); tick();
    wrp(6, 8'h5E); rd1(7); tick();
    rdp(6); tick();

    // increment wrap, bypass of writeback, back-to-back on done
    wr1(3, 4'hF); tick();
    inc(3); tick(); inc_st("wrapA", 1, 0, 0);
    tick(); inc_st("wrapB", 1, 0, 0);
    m[3] = 4'h0; rd1(3); tick(); inc_st("wrapC", 0, 1, 1);
    inc(3); tick(); inc_st("b2bA", 1, 0, 0);
    tick(); inc_st("b2bB", 1, 0, 0);
    tick(); inc_st("b2bC", 0, 1, 0);
    m[3] = 4'h1; rd1(3); tick(); inc_st("b2b_after", 0, 0, 0);
    chk("zero_held", inc_zero, 0);

    // write to target in capture cycle is part of the operand
    inc(5); tick();
    wr1(5, 4'h7); tick();
    tick(); inc_st("capwr", 0, 1, 0);
    m[5] = 4'h8; rd1(5); tick();

    // busy ignore, write wins at writeback
    wr1(2, 4'h4); tick();
    wr1(9, 4'h7); tick();
    inc(2); tick();
    inc(9); tick();
    wr1(2, 4'hB); tick(); inc_st("conf", 0, 1, 0);
    rd1(2); tick(); inc_st("conf_idle", 0, 0, 0);
    rd1(9); tick();
    tick(); tick(); inc_st("ignored", 0, 0, 0);
    rd1(9); tick();

    // reset during capture discards the increment
    wr1(8, 4'h6); tick();
    inc(8); tick(); inc_st("rstinc", 1, 0, 0);
    reset = 1; tick(); reset = 0;
    foreach (m[i]) m[i] = '0;
    inc_st("rstinc_after", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin tick(); inc_st("rstinc_quiet", 0, 0, 0); end
    rd1(8); tick();

    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
